// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel/sync bundle types and test-pattern colours.
// Test-pattern bar colours are only used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_LAT = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_bundle_t;

    localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, active: 1'b0};

    localparam rgb_t RGB_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t RGB_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t RGB_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t RGB_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t RGB_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam rgb_t RGB_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t RGB_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t RGB_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

    function automatic rgb_t pattern_color(input logic [2:0] bar);
        rgb_t c;
        case (bar)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Delay line for the {hs, vs, active} bundle so sync/blank line up with the
// colour returned by the compositor pipeline. DEPTH = 0 is a plain wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            sync_bundle_t stage_r [DEPTH];

            // Shift one stage per clock; reset flushes every stage to the inactive bundle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= SYNC_IDLE;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// VGA counters, sync/blank generation delayed to match compositor latency, and registered DAC pins.
// Optional build macro VGA_TEST_PATTERN_EN replaces RGB_i with eight vertical colour bars.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] RGB_i,
    output logic [31:0] vga_x_pos_o,
    output logic [31:0] vga_y_pos_o,
    output logic        frame_start_o,
    output logic        vga_hs_n_o,
    output logic        vga_vs_n_o,
    output logic        vga_blank_n_o,
    output logic        vga_sync_n_o,
    output logic [7:0]  vga_r_o,
    output logic [7:0]  vga_g_o,
    output logic [7:0]  vga_b_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W      = $clog2(H_TOTAL + 1);
    localparam int V_W      = $clog2(V_TOTAL + 1);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [H_W-1:0] h_cnt_r;
    logic [H_W-1:0] h_nxt_s;
    logic [V_W-1:0] v_cnt_r;
    logic [V_W-1:0] v_nxt_s;
    logic           started_r;
    logic           frame_start_r;
    sync_bundle_t   bundle_s;
    sync_bundle_t   bundle_dly_s;
    logic           hs_n_r;
    logic           vs_n_r;
    logic           blank_n_r;
    rgb_t           rgb_src_s;
    rgb_t           rgb_r;

    // Next counter values: line counter steps only on the pixel counter wrap
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_W'(H_TOTAL - 1)) begin
            h_nxt_s = '0;
            if (v_cnt_r == V_W'(V_TOTAL - 1)) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + V_W'(1);
            end
        end else begin
            h_nxt_s = h_cnt_r + H_W'(1);
        end
    end

    // Counters; the first clock after reset presents (0,0) once before counting so no partial line escapes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_r     <= 1'b0;
            h_cnt_r       <= '0;
            v_cnt_r       <= '0;
            frame_start_r <= 1'b0;
        end else if (!started_r) begin
            started_r     <= 1'b1;
            frame_start_r <= 1'b1;
        end else begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            frame_start_r <= (h_nxt_s == '0) && (v_nxt_s == '0);
        end
    end

    // Sync/active decode for the coordinate currently issued
    always_comb begin
        bundle_s = SYNC_IDLE;
        if (started_r) begin
            bundle_s.hs     = (h_cnt_r >= H_W'(HS_START)) && (h_cnt_r < H_W'(HS_END));
            bundle_s.vs     = (v_cnt_r >= V_W'(VS_START)) && (v_cnt_r < V_W'(VS_END));
            bundle_s.active = (h_cnt_r < H_W'(H_ACTIVE)) && (v_cnt_r < V_W'(V_ACTIVE));
        end else begin
            bundle_s = SYNC_IDLE;
        end
    end

    vga_sync_delay #(
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bundle_s),
        .dout  (bundle_dly_s)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_s;
    logic [2:0] bar_dly_s;

    assign bar_s = 3'(h_cnt_r / H_W'(H_ACTIVE / 8));

    if (PIPE_LAT == 0) begin : g_bar_bypass
        assign bar_dly_s = bar_s;
    end else begin : g_bar_shift
        logic [2:0] bar_r [PIPE_LAT];

        // Bar index follows the same delay as the sync bundle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    bar_r[i] <= 3'd0;
                end
            end else begin
                bar_r[0] <= bar_s;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    bar_r[i] <= bar_r[i-1];
                end
            end
        end

        assign bar_dly_s = bar_r[PIPE_LAT-1];
    end

    assign rgb_src_s = pattern_color(bar_dly_s);
`else
    assign rgb_src_s = RGB_i;
`endif

    // Output pin register: colour forced to black outside the visible region
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_n_r    <= 1'b1;
            vs_n_r    <= 1'b1;
            blank_n_r <= 1'b0;
            rgb_r     <= RGB_BLACK;
        end else begin
            hs_n_r    <= ~bundle_dly_s.hs;
            vs_n_r    <= ~bundle_dly_s.vs;
            blank_n_r <= bundle_dly_s.active;
            rgb_r     <= bundle_dly_s.active ? rgb_src_s : RGB_BLACK;
        end
    end

    assign vga_x_pos_o   = 32'(h_cnt_r);
    assign vga_y_pos_o   = 32'(v_cnt_r);
    assign frame_start_o = frame_start_r;
    assign vga_hs_n_o    = hs_n_r;
    assign vga_vs_n_o    = vs_n_r;
    assign vga_blank_n_o = blank_n_r;
    assign vga_sync_n_o  = 1'b0;
    assign vga_r_o       = rgb_r.r;
    assign vga_g_o       = rgb_r.g;
    assign vga_b_o       = rgb_r.b;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator using a reduced 24x10 timing so whole frames fit.
module tb_vga_timing_generator;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
    localparam int PL = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] RGB_i;
    logic [31:0] vga_x_pos_o, vga_y_pos_o;
    logic        frame_start_o, vga_hs_n_o, vga_vs_n_o, vga_blank_n_o, vga_sync_n_o;
    logic [7:0]  vga_r_o, vga_g_o, vga_b_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] rgb_hist [int];

    vga_timing_generator #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RGB_i(RGB_i),
        .vga_x_pos_o(vga_x_pos_o), .vga_y_pos_o(vga_y_pos_o),
        .frame_start_o(frame_start_o),
        .vga_hs_n_o(vga_hs_n_o), .vga_vs_n_o(vga_vs_n_o),
        .vga_blank_n_o(vga_blank_n_o), .vga_sync_n_o(vga_sync_n_o),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o)
    );

    always #5 clk = ~clk;

    // {hs_n, vs_n, blank_n, sync_n, rgb}
    function automatic logic [27:0] pins_of(input logic hs_n, input logic vs_n,
                                            input logic bl_n, input logic [23:0] rgb);
        return {hs_n, vs_n, bl_n, 1'b0, rgb};
    endfunction

    localparam logic [27:0] PINS_RESET = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    function automatic logic [27:0] dut_pins();
        return {vga_hs_n_o, vga_vs_n_o, vga_blank_n_o, vga_sync_n_o, vga_r_o, vga_g_o, vga_b_o};
    endfunction

    function automatic logic [23:0] pix_color(input int px, input logic [23:0] rgb);
`ifdef VGA_TEST_PATTERN_EN
        case (px / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return rgb;
`endif
    endfunction

    // Reference: clock k after release issues raster index k-1; pins at k show index k-PL-2
    function automatic void model(input int k, output logic [31:0] ex, output logic [31:0] ey,
                                  output logic efs, output logic [27:0] epins);
        int n, p, px, py;
        logic act, hs, vs;
        ex = 32'd0; ey = 32'd0; efs = 1'b0;
        if (k >= 1) begin
            n   = k - 1;
            ex  = 32'(n % HT);
            ey  = 32'((n / HT) % VT);
            efs = ((n % (HT * VT)) == 0);
        end
        p = k - PL - 2;
        if (p < 0) begin
            epins = PINS_RESET;
        end else begin
            px  = p % HT;
            py  = (p / HT) % VT;
            act = (px < HA) && (py < VA);
            hs  = (px >= HA + HFP) && (px < HA + HFP + HSW);
            vs  = (py >= VA + VFP) && (py < VA + VFP + VSW);
            epins = pins_of(!hs, !vs, act, act ? pix_color(px, rgb_hist[k-1]) : 24'h000000);
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input int k);
        logic [31:0] ex, ey;
        logic efs;
        logic [27:0] ep;
        model(k, ex, ey, efs, ep);
        chk($sformatf("xy k=%0d", k), {vga_x_pos_o, vga_y_pos_o}, {ex, ey});
        chk($sformatf("frame_start k=%0d", k), 64'(frame_start_o), 64'(efs));
        chk($sformatf("pins k=%0d", k), 64'(dut_pins()), 64'(ep));
    endtask

    task automatic drive(input int k, input logic [23:0] v);
        rgb_hist[k] = v;
        RGB_i = v;
    endtask

    typedef struct {
        int          k;
        logic [31:0] x;
        logic [31:0] y;
        logic        fs;
        logic [27:0] pins;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [23:0] c_x2, c_x15;
        int tbl_i;
        int fs_q[$];
        int hs_fall_q[$];
        int hs_len_q[$];
        int vs_len_q[$];
        int hs_fall_k, vs_fall_k;
        logic prev_hs, prev_vs;

`ifdef VGA_TEST_PATTERN_EN
        c_x2  = 24'hFFFF00;
        c_x15 = 24'h000000;
`else
        c_x2  = 24'hFFFFFF;
        c_x15 = 24'hFFFFFF;
`endif
        tbl[0]  = '{1,   32'd0,  32'd0, 1'b1, PINS_RESET};
        tbl[1]  = '{3,   32'd2,  32'd0, 1'b0, PINS_RESET};
        tbl[2]  = '{4,   32'd3,  32'd0, 1'b0, pins_of(1'b1, 1'b1, 1'b1, 24'hFFFFFF)};
        tbl[3]  = '{6,   32'd5,  32'd0, 1'b0, pins_of(1'b1, 1'b1, 1'b1, c_x2)};
        tbl[4]  = '{19,  32'd18, 32'd0, 1'b0, pins_of(1'b1, 1'b1, 1'b1, c_x15)};
        tbl[5]  = '{20,  32'd19, 32'd0, 1'b0, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[6]  = '{22,  32'd21, 32'd0, 1'b0, pins_of(1'b0, 1'b1, 1'b0, 24'h0)};
        tbl[7]  = '{24,  32'd23, 32'd0, 1'b0, pins_of(1'b0, 1'b1, 1'b0, 24'h0)};
        tbl[8]  = '{25,  32'd0,  32'd1, 1'b0, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[9]  = '{139, 32'd18, 32'd5, 1'b0, pins_of(1'b1, 1'b1, 1'b1, c_x15)};
        tbl[10] = '{148, 32'd3,  32'd6, 1'b0, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[11] = '{171, 32'd2,  32'd7, 1'b0, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[12] = '{172, 32'd3,  32'd7, 1'b0, pins_of(1'b1, 1'b0, 1'b0, 24'h0)};
        tbl[13] = '{219, 32'd2,  32'd9, 1'b0, pins_of(1'b1, 1'b0, 1'b0, 24'h0)};
        tbl[14] = '{220, 32'd3,  32'd9, 1'b0, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[15] = '{241, 32'd0,  32'd0, 1'b1, pins_of(1'b1, 1'b1, 1'b0, 24'h0)};
        tbl[16] = '{244, 32'd3,  32'd0, 1'b0, pins_of(1'b1, 1'b1, 1'b1, 24'hFFFFFF)};

        rst_n = 1'b0;
        RGB_i = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hold pins", 64'(dut_pins()), 64'(PINS_RESET));
        chk("reset hold xy/fs", {31'd0, frame_start_o, vga_x_pos_o}, 64'd0);

        // Constant white input: table vectors plus model on every clock
        @(negedge clk);
        rst_n = 1'b1;
        rgb_hist.delete();
        drive(0, 24'hFFFFFF);
        #1;
        check_model(0);
        tbl_i = 0;
        for (int k = 1; k <= 244; k++) begin
            @(posedge clk);
            #1;
            check_model(k);
            while (tbl_i < 17 && tbl[tbl_i].k == k) begin
                chk($sformatf("tbl xy k=%0d", k), {vga_x_pos_o, vga_y_pos_o}, {tbl[tbl_i].x, tbl[tbl_i].y});
                chk($sformatf("tbl fs k=%0d", k), 64'(frame_start_o), 64'(tbl[tbl_i].fs));
                chk($sformatf("tbl pins k=%0d", k), 64'(dut_pins()), 64'(tbl[tbl_i].pins));
                tbl_i++;
            end
            drive(k, 24'hFFFFFF);
        end

        // Random colour, then x-replicated colour
        for (int k = 245; k <= 844; k++) begin
            @(posedge clk);
            #1;
            check_model(k);
            if (k < 545) begin
                drive(k, 24'($urandom));
            end else begin
                drive(k, {3{8'((k - 1) % HT)}});
            end
        end

        // Mid-frame reset: pins drop immediately and the raster restarts at the origin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midframe reset pins", 64'(dut_pins()), 64'(PINS_RESET));
        chk("midframe reset xy/fs", {31'd0, frame_start_o, vga_x_pos_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held pins", 64'(dut_pins()), 64'(PINS_RESET));
        @(negedge clk);
        rst_n = 1'b1;
        rgb_hist.delete();
        drive(0, 24'($urandom));
        #1;
        check_model(0);
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        hs_fall_k = 0;
        vs_fall_k = 0;
        for (int k = 1; k <= 520; k++) begin
            @(posedge clk);
            #1;
            check_model(k);
            if (frame_start_o) fs_q.push_back(k);
            if (prev_hs && !vga_hs_n_o) begin
                hs_fall_k = k;
                hs_fall_q.push_back(k);
            end
            if (!prev_hs && vga_hs_n_o) hs_len_q.push_back(k - hs_fall_k);
            if (prev_vs && !vga_vs_n_o) vs_fall_k = k;
            if (!prev_vs && vga_vs_n_o) vs_len_q.push_back(k - vs_fall_k);
            prev_hs = vga_hs_n_o;
            prev_vs = vga_vs_n_o;
            drive(k, 24'($urandom));
        end

        chk("frame_start count", 64'(fs_q.size()), 64'd3);
        if (fs_q.size() >= 2) begin
            chk("frame_start first", 64'(fs_q[0]), 64'd1);
            chk("frame period", 64'(fs_q[1] - fs_q[0]), 64'(HT * VT));
        end
        if (hs_fall_q.size() >= 1 && hs_len_q.size() >= 1) begin
            chk("hsync first fall", 64'(hs_fall_q[0]), 64'(1 + HA + HFP + PL + 1));
            chk("hsync width", 64'(hs_len_q[0]), 64'(HSW));
        end else begin
            chk("hsync seen", 64'(hs_len_q.size()), 64'd1);
        end
        if (vs_len_q.size() >= 1) begin
            chk("vsync width", 64'(vs_len_q[0]), 64'(VSW * HT));
        end else begin
            chk("vsync seen", 64'(vs_len_q.size()), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Pixel-clock timing generator and output stage for the VGA path. Free-running horizontal and vertical counters produce the pixel coordinates consumed by the sprite/compositor chain. The block takes back the composed 24-bit colour after that chain's fixed pipeline latency and delays hsync/vsync/blank to match, so the DAC sees colour and sync aligned. It emits the registered VGA pins for the board DAC.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- PIPE_LAT, 2, clocks from vga_x_pos_o/vga_y_pos_o to the matching RGB_i; legal range 0..7

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal); the same clock drives the sprite memories
- rst_n  in  1  asynchronous, active-low reset
- RGB_i  in  24  composed colour {R,G,B} for the coordinates issued PIPE_LAT clocks earlier
- vga_x_pos_o  out  32  current horizontal count, zero-extended
- vga_y_pos_o  out  32  current vertical count, zero-extended
- frame_start_o  out  1  one-clock pulse while counters are at (0,0)
- vga_hs_n_o  out  1  horizontal sync, active low
- vga_vs_n_o  out  1  vertical sync, active low
- vga_blank_n_o  out  1  high during visible pixels
- vga_sync_n_o  out  1  DAC composite sync, tied low
- vga_r_o, vga_g_o, vga_b_o  out  8 each  registered colour

## Operation
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 x 525.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments only on the h_cnt wrap clock, runs 0..V_TOTAL-1, and wraps to 0.
- Visible region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync windows:
  - hsync active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- vga_x_pos_o/vga_y_pos_o come straight from the counter registers and are valid during blanking too. Downstream controllers must not rely on blanking values.
- {hs, vs, active} pass through a PIPE_LAT-deep delay line, then one output register.
- Colour output register loads RGB_i when the delayed active bit is 1, else 24'h000000.
- Counters are a two-level counter. No other FSM.

## Timing
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0.
  - Delay line loads {hs=0, vs=0, active=0}.
  - vga_hs_n_o = vga_vs_n_o = 1, vga_blank_n_o = 0, colour = 0, frame_start_o = 0, vga_sync_n_o = 0.
- First clock after release: counters start advancing. frame_start_o asserts in that first clock, when the counters read (0,0).
- Latency: coordinates C issued at clock t; RGB_i for C is sampled at clock t+PIPE_LAT; pins show C with its sync/blank at t+PIPE_LAT+1.
- PIPE_LAT = 0: delay line is absent; only the output register remains (latency 1).
- Frame period: H_TOTAL*V_TOTAL clocks (420000 at defaults). frame_start_o pulses once per frame.
- Simultaneous h and v wrap at (799,524): both counters go to 0 on the same edge.
- Reset mid-frame: all outputs return to reset values immediately. No partial line is emitted after release.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - RGB_i is ignored.
  - Colour comes from the delayed x coordinate as 8 vertical bars of H_ACTIVE/8 pixels: white, yellow, cyan, green, magenta, red, blue, black.
  - Blanking and latency are unchanged.
- Undefined: RGB_i is used as described. No pattern logic is synthesised.

## Structure
- Package vga_pkg holds:
  - default timing constants;
  - typedef rgb_t (struct of three 8-bit fields);
  - typedef sync_bundle_t {hs, vs, active};
  - the test-pattern colour constants.
- Sub-module vga_sync_delay: parameterised shift register of sync_bundle_t, depth PIPE_LAT, async active-low reset to the inactive bundle.

## Test plan
- Reset held, then released: pins stay hs_n=1, vs_n=1, blank_n=0, RGB=0 through clock PIPE_LAT; frame_start_o = 1 on the first clock after release.
- Free run one line: vga_hs_n_o low for exactly 96 clocks, falling edge 656+PIPE_LAT+1 clocks after x=0.
- Free run two frames: frame_start_o pulses 420000 clocks apart; vga_vs_n_o low for 1600 clocks (2 lines).
- RGB_i = 24'hFFFFFF constant, PIPE_LAT = 2: pins show white for 640 clocks per visible line and 0 elsewhere, including lines 480..524.
- RGB_i = x[7:0] replicated: pin colour at pin clock n equals the x issued at clock n-3.
- rst_n pulsed low at (x=300, y=200): pins go inactive immediately; after release, counters restart at (0,0) and frame_start_o pulses.
- VGA_TEST_PATTERN_EN defined: pixel x=0 is FFFFFF, x=80 is FFFF00, x=639 is 000000.
